// File: rtl/sprite_line_scheduler_pkg.sv
// sprite_pkg: shared types and constants for the sprite line scheduler.
//
// Build option: define SPRITE_SCHED_HFLIP_EN to add a per-sprite horizontal
// flip bit (attribute bit 25). The default build has a 25-bit attribute word
// and never mirrors sprites.
package sprite_pkg;

  localparam int NUM_SPRITES  = 20;
  localparam int MAX_PER_LINE = 4;
  localparam int SPRITE_W     = 32;  // power of two
  localparam int SPRITE_H     = 32;  // power of two
  localparam int H_ACTIVE     = 640;

  localparam int ID_W    = 5;
  localparam int COORD_W = 10;
  localparam int RGB_W   = 24;
  localparam logic [RGB_W-1:0] TRANSPARENT = 24'h0;

  localparam int COL_W       = $clog2(SPRITE_W);
  localparam int ROW_W       = $clog2(SPRITE_H);
  localparam int SLOT_IDX_W  = $clog2(MAX_PER_LINE);
  localparam int SLOT_CNT_W  = $clog2(MAX_PER_LINE + 1);
  localparam int ATTR_ADDR_W = $clog2(NUM_SPRITES + 1);
  localparam int ROM_ADDR_W  = ID_W + ROW_W + COL_W;

`ifdef SPRITE_SCHED_HFLIP_EN
  localparam int ATTR_W = 1 + ID_W + 2 * COORD_W;

  typedef struct packed {
    logic               hflip;
    logic [ID_W-1:0]    id;
    logic [COORD_W-1:0] y;
    logic [COORD_W-1:0] x;
  } sprite_attr_t;

  typedef struct packed {
    logic               hflip;
    logic [ID_W-1:0]    id;
    logic [COORD_W-1:0] x;
    logic [ROW_W-1:0]   row;
  } slot_t;
`else
  localparam int ATTR_W = ID_W + 2 * COORD_W;

  typedef struct packed {
    logic [ID_W-1:0]    id;
    logic [COORD_W-1:0] y;
    logic [COORD_W-1:0] x;
  } sprite_attr_t;

  typedef struct packed {
    logic [ID_W-1:0]    id;
    logic [COORD_W-1:0] x;
    logic [ROW_W-1:0]   row;
  } slot_t;
`endif

  typedef enum logic [1:0] {IDLE, SCAN, FETCH, DONE} sched_state_t;

endpackage

// File: rtl/sprite_line_scheduler_if.sv
// sprite_line_scheduler_if: all non-clock/reset signals of the scheduler.
//   job control : line_start, next_line -> busy, done, overflow, late
//   attribute   : attr_addr -> attr_data (registered read, 1 cycle later)
//   sprite ROM  : rom_req/rom_addr -> rom_gnt, rom_data
//   line buffer : lb_we, lb_waddr, lb_wdata
//   debug       : dbg_state (scheduler FSM state)
// Modport slave is the scheduler side, master is the environment side.
//
// ROM handshake: rom_req with rom_addr is held stable until a cycle in which
// rom_gnt is also high; that cycle is the accept, and rom_data for it is
// valid during exactly the following cycle. rom_gnt without rom_req has no
// effect.
interface sprite_line_scheduler_if;
  import sprite_pkg::*;

  logic                   line_start;
  logic [COORD_W-1:0]     next_line;
  logic [ATTR_ADDR_W-1:0] attr_addr;
  logic [ATTR_W-1:0]      attr_data;
  logic                   rom_req;
  logic [ROM_ADDR_W-1:0]  rom_addr;
  logic                   rom_gnt;
  logic [RGB_W-1:0]       rom_data;
  logic                   lb_we;
  logic [COORD_W-1:0]     lb_waddr;
  logic [RGB_W-1:0]       lb_wdata;
  logic                   busy;
  logic                   done;
  logic                   overflow;
  logic                   late;
  sched_state_t           dbg_state;

  modport slave (
    input  line_start, next_line, attr_data, rom_gnt, rom_data,
    output attr_addr, rom_req, rom_addr, lb_we, lb_waddr, lb_wdata,
    output busy, done, overflow, late, dbg_state
  );

  modport master (
    output line_start, next_line, attr_data, rom_gnt, rom_data,
    input  attr_addr, rom_req, rom_addr, lb_we, lb_waddr, lb_wdata,
    input  busy, done, overflow, late, dbg_state
  );
endinterface

// File: rtl/sprite_line_scheduler_slot_list.sv
// sprite_slot_list: MAX_PER_LINE-entry register file of selected sprites.
//   clk, reset   : clock, asynchronous active-low reset
//   clear        : empty the list (wins over push)
//   push         : append push_slot; ignored when the list is full
//   count        : number of valid entries
//   rd_idx       : combinational read index -> rd_slot
module sprite_slot_list
  import sprite_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  push,
  input  slot_t                 push_slot,
  output logic [SLOT_CNT_W-1:0] count,
  input  logic [SLOT_IDX_W-1:0] rd_idx,
  output slot_t                 rd_slot
);

  slot_t                 slots_q [MAX_PER_LINE];
  slot_t                 slots_d [MAX_PER_LINE];
  logic [SLOT_CNT_W-1:0] count_q, count_d;

  always_comb begin
    slots_d = slots_q;
    count_d = count_q;
    if (clear) begin
      for (int i = 0; i < MAX_PER_LINE; i++) slots_d[i] = '0;
      count_d = '0;
    end else if (push && (count_q != SLOT_CNT_W'(MAX_PER_LINE))) begin
      slots_d[count_q[SLOT_IDX_W-1:0]] = push_slot;
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < MAX_PER_LINE; i++) slots_q[i] <= '0;
      count_q <= '0;
    end else begin
      slots_q <= slots_d;
      count_q <= count_d;
    end
  end

  assign count   = count_q;
  assign rd_slot = slots_q[rd_idx];

endmodule

// File: rtl/sprite_line_scheduler.sv
// sprite_line_scheduler: per-scanline sprite selection and prefetch.
//   clk, reset : clock, asynchronous active-low reset
//   bus        : sprite_line_scheduler_if.slave (job control, attribute
//                read port, sprite ROM port, line buffer write port, debug)
// A job scans the attribute table for sprites covering next_line, keeps the
// first MAX_PER_LINE hits, then reads each kept sprite's row from the ROM and
// writes its opaque, on-screen pixels into the line buffer. Slots are drained
// from the highest index down so sprite 0 is written last and wins overlaps.
// Build option: SPRITE_SCHED_HFLIP_EN enables per-sprite horizontal mirroring.
module sprite_line_scheduler
  import sprite_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  sprite_line_scheduler_if.slave bus
);

  sched_state_t           state_q, state_d;
  logic [COORD_W-1:0]     line_q, line_d;
  logic [ATTR_ADDR_W-1:0] scan_q, scan_d;
  logic [SLOT_IDX_W-1:0]  fidx_q, fidx_d;
  logic [COL_W-1:0]       col_q, col_d;
  logic                   rom_req_q, rom_req_d;
  logic                   wr_pend_q, wr_pend_d;
  logic [COORD_W:0]       wr_x_q, wr_x_d;
  logic                   overflow_q, overflow_d;
  logic                   late_q, late_d;

  sprite_attr_t          attr;
  logic [COORD_W-1:0]    dy;
  logic                  hit;
  logic                  slot_push, slot_clear, slots_full;
  logic [SLOT_CNT_W-1:0] slot_count, count_after;
  slot_t                 new_slot, cur_slot;
  logic [COL_W-1:0]      rom_col;

  assign attr = sprite_attr_t'(bus.attr_data);
  // Modulo-2^10 distance: lines above the sprite wrap to large values and miss.
  assign dy   = line_q - attr.y;
  assign hit  = (attr.id != '0) && (dy[COORD_W-1:ROW_W] == '0);

  assign new_slot.id  = attr.id;
  assign new_slot.x   = attr.x;
  assign new_slot.row = dy[ROW_W-1:0];
`ifdef SPRITE_SCHED_HFLIP_EN
  assign new_slot.hflip = attr.hflip;
  // SPRITE_W is a power of two, so SPRITE_W-1-col is the bitwise inverse.
  assign rom_col = cur_slot.hflip ? ~col_q : col_q;
`else
  assign rom_col = col_q;
`endif

  assign slots_full  = (slot_count == SLOT_CNT_W'(MAX_PER_LINE));
  assign count_after = slot_count + SLOT_CNT_W'(slot_push);

  sprite_slot_list u_slots (
    .clk       (clk),
    .reset     (reset),
    .clear     (slot_clear),
    .push      (slot_push),
    .push_slot (new_slot),
    .count     (slot_count),
    .rd_idx    (fidx_q),
    .rd_slot   (cur_slot)
  );

  always_comb begin
    state_d    = state_q;
    line_d     = line_q;
    scan_d     = scan_q;
    fidx_d     = fidx_q;
    col_d      = col_q;
    rom_req_d  = rom_req_q;
    wr_pend_d  = 1'b0;
    wr_x_d     = wr_x_q;
    overflow_d = overflow_q;
    late_d     = 1'b0;
    slot_push  = 1'b0;
    slot_clear = 1'b0;

    if (bus.line_start) begin
      // New job always wins; an unfinished job is abandoned, including any
      // accepted read whose data would arrive next cycle.
      late_d     = (state_q != IDLE);
      line_d     = bus.next_line;
      overflow_d = 1'b0;
      slot_clear = 1'b1;
      scan_d     = '0;
      col_d      = '0;
      rom_req_d  = 1'b0;
      state_d    = SCAN;
    end else begin
      case (state_q)
        IDLE: ;
        SCAN: begin
          scan_d = scan_q + 1'b1;
          // attr_data seen now belongs to the address issued one cycle ago.
          if ((scan_q != '0) && hit) begin
            if (slots_full) overflow_d = 1'b1;
            else            slot_push  = 1'b1;
          end
          if (scan_q == ATTR_ADDR_W'(NUM_SPRITES)) begin
            scan_d = '0;
            if (count_after != '0) begin
              fidx_d    = SLOT_IDX_W'(count_after - 1'b1);
              col_d     = '0;
              rom_req_d = 1'b1;
              state_d   = FETCH;
            end else begin
              state_d = DONE;
            end
          end
        end
        FETCH: begin
          if (rom_req_q) begin
            if (bus.rom_gnt) begin
              wr_pend_d = 1'b1;
              wr_x_d    = (COORD_W+1)'(cur_slot.x) + (COORD_W+1)'(col_q);
              col_d     = col_q + 1'b1;
              if (&col_q) begin
                if (fidx_q == '0) rom_req_d = 1'b0;
                else              fidx_d    = fidx_q - 1'b1;
              end
            end
          end else begin
            // One drain cycle for the last write, then finish.
            state_d = DONE;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      line_q     <= '0;
      scan_q     <= '0;
      fidx_q     <= '0;
      col_q      <= '0;
      rom_req_q  <= 1'b0;
      wr_pend_q  <= 1'b0;
      wr_x_q     <= '0;
      overflow_q <= 1'b0;
      late_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      line_q     <= line_d;
      scan_q     <= scan_d;
      fidx_q     <= fidx_d;
      col_q      <= col_d;
      rom_req_q  <= rom_req_d;
      wr_pend_q  <= wr_pend_d;
      wr_x_q     <= wr_x_d;
      overflow_q <= overflow_d;
      late_q     <= late_d;
    end
  end

  // line_start gates the request and the pending write in the same cycle so
  // an abandoned job neither issues nor completes another access.
  assign bus.rom_req   = rom_req_q & ~bus.line_start;
  assign bus.rom_addr  = rom_req_q ? {cur_slot.id, cur_slot.row, rom_col} : '0;
  assign bus.lb_we     = wr_pend_q & ~bus.line_start
                       & (bus.rom_data != TRANSPARENT)
                       & (wr_x_q < (COORD_W+1)'(H_ACTIVE));
  assign bus.lb_waddr  = bus.lb_we ? wr_x_q[COORD_W-1:0] : '0;
  assign bus.lb_wdata  = bus.lb_we ? bus.rom_data : '0;
  assign bus.attr_addr = scan_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = (state_q == DONE);
  assign bus.overflow  = overflow_q;
  assign bus.late      = late_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_sprite_line_scheduler.sv
// Testbench for sprite_line_scheduler. Inputs change 1ns after the rising
// edge; outputs are observed on the falling edge. The attribute table and
// the sprite ROM are modelled here; expected line buffer writes come from a
// model that applies the selection and drawing rules directly.
module tb_sprite_line_scheduler;
  import sprite_pkg::*;

  logic clk;
  logic reset;
  sprite_line_scheduler_if bus ();

  sprite_line_scheduler dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [ID_W-1:0]    tab_id [NUM_SPRITES];
  logic [COORD_W-1:0] tab_y  [NUM_SPRITES];
  logic [COORD_W-1:0] tab_x  [NUM_SPRITES];
  logic               tab_hf [NUM_SPRITES];

  logic [COORD_W+RGB_W-1:0] exp_q[$];
  logic [COORD_W+RGB_W-1:0] got_q[$];
  int   exp_k;
  logic exp_ovf;

  bit                     gnt_random = 1'b0;
  logic                   acc_n = 1'b0;
  logic [ROM_ADDR_W-1:0]  acc_addr_n = '0;
  logic [ATTR_ADDR_W-1:0] attr_a_n = '0;
  int                     acc_cnt = 0;
  int                     req_cnt = 0;
  logic [ROM_ADDR_W-1:0]  first_addr = '0;

  function automatic logic [RGB_W-1:0] rom_fn(input logic [ROM_ADDR_W-1:0] a);
    if (a[2:0] == 3'd5) return TRANSPARENT;
    return {4'hA, a, 5'h1b};
  endfunction

  function automatic logic [ATTR_W-1:0] mk_attr(input int i);
    logic [ATTR_W-1:0] a;
    a = '0;
    if (i < NUM_SPRITES) begin
      a[24:20] = tab_id[i];
      a[19:10] = tab_y[i];
      a[9:0]   = tab_x[i];
`ifdef SPRITE_SCHED_HFLIP_EN
      a[25]    = tab_hf[i];
`endif
    end
    return a;
  endfunction

  // Observation: accepts, requests and line buffer writes of the current cycle.
  always @(negedge clk) begin
    acc_n      = (bus.rom_req === 1'b1) && (bus.rom_gnt === 1'b1);
    acc_addr_n = bus.rom_addr;
    attr_a_n   = bus.attr_addr;
    if (bus.rom_req === 1'b1) req_cnt++;
    if (acc_n) begin
      if (acc_cnt == 0) first_addr = bus.rom_addr;
      acc_cnt++;
    end
    if (bus.lb_we === 1'b1) got_q.push_back({bus.lb_waddr, bus.lb_wdata});
  end

  // Attribute RAM and sprite ROM: data one cycle after address / accept.
  always @(posedge clk) begin
    #1;
    bus.attr_data = mk_attr(int'(attr_a_n));
    bus.rom_data  = acc_n ? rom_fn(acc_addr_n) : (RGB_W'($urandom) | 24'h1);
    bus.rom_gnt   = gnt_random ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic clear_table();
    for (int i = 0; i < NUM_SPRITES; i++) begin
      tab_id[i] = '0; tab_y[i] = '0; tab_x[i] = '0; tab_hf[i] = 1'b0;
    end
  endtask

  task automatic set_sprite(input int i, input int id, input int y, input int x);
    tab_id[i] = ID_W'(id);
    tab_y[i]  = COORD_W'(y);
    tab_x[i]  = COORD_W'(x);
  endtask

  // Expected writes: first MAX_PER_LINE covering sprites in table order,
  // drawn from the last kept one back to the first.
  task automatic build_model(input logic [COORD_W-1:0] line);
    int hits[$];
    int dy, s, xx, rc;
    bit hf;
    logic [ROM_ADDR_W-1:0] a;
    logic [RGB_W-1:0] d;
    exp_q.delete();
    exp_ovf = 1'b0;
    for (int i = 0; i < NUM_SPRITES; i++) begin
      dy = (int'(line) - int'(tab_y[i]) + 1024) % 1024;
      if (tab_id[i] != 0 && dy < SPRITE_H) begin
        if (hits.size() < MAX_PER_LINE) hits.push_back(i);
        else exp_ovf = 1'b1;
      end
    end
    exp_k = hits.size();
    for (int h = exp_k - 1; h >= 0; h--) begin
      s  = hits[h];
      dy = (int'(line) - int'(tab_y[s]) + 1024) % 1024;
      hf = 1'b0;
`ifdef SPRITE_SCHED_HFLIP_EN
      hf = tab_hf[s];
`endif
      for (int c = 0; c < SPRITE_W; c++) begin
        xx = int'(tab_x[s]) + c;
        rc = hf ? (SPRITE_W - 1 - c) : c;
        a  = {tab_id[s], 5'(dy), 5'(rc)};
        d  = rom_fn(a);
        if (d != TRANSPARENT && xx < H_ACTIVE) exp_q.push_back({10'(xx), d});
      end
    end
  endtask

  task automatic start_line(input logic [COORD_W-1:0] line);
    @(posedge clk); #1;
    bus.line_start = 1'b1;
    bus.next_line  = line;
    got_q.delete();
    acc_cnt = 0;
    req_cnt = 0;
    @(posedge clk); #1;
    bus.line_start = 1'b0;
  endtask

  task automatic finish_job(input string name, input bit chk_lat);
    int cyc, exp_lat, mism;
    bit seen;
    cyc = 1;
    seen = 1'b0;
    while (!seen && cyc < 4000) begin
      @(negedge clk);
      if (bus.done === 1'b1) seen = 1'b1;
      else begin @(posedge clk); cyc++; end
    end
    checks++;
    if (!seen) begin
      errors++; $display("FAIL %s_done: done not seen after %0d cycles", name, cyc);
    end
    if (seen) begin
      checks++;
      if (bus.overflow !== exp_ovf) begin
        errors++; $display("FAIL %s_overflow: got %b expected %b", name, bus.overflow, exp_ovf);
      end
      if (chk_lat) begin
        exp_lat = (exp_k == 0) ? NUM_SPRITES + 2 : NUM_SPRITES + 1 + exp_k * SPRITE_W + 2;
        checks++;
        if (cyc != exp_lat) begin
          errors++; $display("FAIL %s_latency: got %0d expected %0d", name, cyc, exp_lat);
        end
      end
    end
    @(posedge clk); @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++; $display("FAIL %s_idle: busy=%b done=%b expected 0 0", name, bus.busy, bus.done);
    end
    mism = 0;
    if (got_q.size() == exp_q.size())
      foreach (exp_q[i]) if (got_q[i] !== exp_q[i]) mism++;
    checks++;
    if (got_q.size() != exp_q.size() || mism != 0) begin
      errors++;
      $display("FAIL %s_writes: got %0d writes (%0d differ) expected %0d writes",
               name, got_q.size(), mism, exp_q.size());
    end
    checks++;
    if (acc_cnt != exp_k * SPRITE_W) begin
      errors++; $display("FAIL %s_accepts: got %0d expected %0d", name, acc_cnt, exp_k * SPRITE_W);
    end
  endtask

  task automatic run_job(input logic [COORD_W-1:0] line, input bit rnd, input string name);
    build_model(line);
    gnt_random = rnd;
    start_line(line);
    finish_job(name, !rnd);
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (bus.busy !== 0 || bus.done !== 0 || bus.overflow !== 0 || bus.late !== 0) begin
      errors++; $display("FAIL reset_status: busy=%b done=%b ovf=%b late=%b expected 0",
                         bus.busy, bus.done, bus.overflow, bus.late);
    end
    checks++;
    if (bus.rom_req !== 0 || bus.rom_addr !== 0 || bus.lb_we !== 0 || bus.lb_waddr !== 0
        || bus.lb_wdata !== 0 || bus.attr_addr !== 0) begin
      errors++; $display("FAIL reset_ports: req=%b raddr=%h we=%b waddr=%h wdata=%h aaddr=%h expected 0",
                         bus.rom_req, bus.rom_addr, bus.lb_we, bus.lb_waddr, bus.lb_wdata, bus.attr_addr);
    end
    checks++;
    if (bus.dbg_state !== IDLE) begin
      errors++; $display("FAIL reset_state: got %0d expected %0d", bus.dbg_state, IDLE);
    end
  endtask

  task automatic test_single();
    clear_table();
    set_sprite(0, 1, 100, 200);
    run_job(10'd105, 1'b0, "single");
    checks++;
    if (first_addr !== {5'd1, 5'd5, 5'd0}) begin
      errors++; $display("FAIL single_first_addr: got %h expected %h", first_addr, {5'd1, 5'd5, 5'd0});
    end
    checks++;
    if (bus.late !== 1'b0) begin
      errors++; $display("FAIL single_late: got %b expected 0", bus.late);
    end
  endtask

  task automatic test_no_hit();
    clear_table();
    set_sprite(0, 1, 100, 200);
    run_job(10'd99, 1'b0, "above");
    checks++;
    if (req_cnt != 0) begin
      errors++; $display("FAIL above_req: got %0d request cycles expected 0", req_cnt);
    end
    run_job(10'd132, 1'b0, "below");
    checks++;
    if (req_cnt != 0) begin
      errors++; $display("FAIL below_req: got %0d request cycles expected 0", req_cnt);
    end
    run_job(10'd131, 1'b0, "last_row");
    checks++;
    if (first_addr !== {5'd1, 5'd31, 5'd0}) begin
      errors++; $display("FAIL last_row_addr: got %h expected %h", first_addr, {5'd1, 5'd31, 5'd0});
    end
  endtask

  task automatic test_overlap();
    logic [RGB_W-1:0] img [64];
    logic [RGB_W-1:0] want;
    int bad;
    clear_table();
    set_sprite(0, 1, 10, 50);
    set_sprite(3, 4, 10, 50);
    run_job(10'd12, 1'b1, "overlap");
    foreach (img[i]) img[i] = '0;
    foreach (got_q[i]) if (got_q[i][33:24] >= 50 && got_q[i][33:24] < 114)
      img[got_q[i][33:24] - 50] = got_q[i][23:0];
    bad = 0;
    for (int c = 0; c < SPRITE_W; c++) begin
      want = rom_fn({5'd1, 5'd2, 5'(c)});
      if (want == TRANSPARENT) want = rom_fn({5'd4, 5'd2, 5'(c)});
      if (img[c] !== want) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL overlap_image: got %0d wrong pixels expected 0", bad);
    end
  endtask

  task automatic test_overflow();
    clear_table();
    for (int i = 0; i < 6; i++) set_sprite(i, i + 1, 5 + i, 40 * i);
    run_job(10'd10, 1'b0, "overflow");
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.overflow !== 1'b1) begin
      errors++; $display("FAIL overflow_hold: got %b expected 1", bus.overflow);
    end
    run_job(10'd500, 1'b0, "overflow_clear");
  endtask

  task automatic test_right_edge();
    clear_table();
    set_sprite(0, 7, 300, 620);
    run_job(10'd310, 1'b0, "edge");
    run_job(10'd310, 1'b1, "edge_stall");
  endtask

  task automatic test_random();
    int r;
    for (int it = 0; it < 6; it++) begin
      clear_table();
      for (int i = 0; i < NUM_SPRITES; i++) begin
        r = $urandom_range(0, 3);
        set_sprite(i, (r == 0) ? 0 : $urandom_range(1, 31), $urandom_range(0, 1023),
                   $urandom_range(0, 1023));
        tab_hf[i] = 1'($urandom_range(0, 1));
      end
      r = $urandom_range(0, NUM_SPRITES - 1);
      run_job(10'(int'(tab_y[r]) + $urandom_range(0, 40)), 1'(it % 2), "random");
    end
  endtask

  task automatic test_late();
    clear_table();
    set_sprite(0, 2, 20, 100);
    set_sprite(1, 3, 22, 110);
    set_sprite(5, 9, 300, 10);
    gnt_random = 1'b0;
    start_line(10'd25);
    repeat (35) @(posedge clk);
    build_model(10'd301);
    #1;
    bus.line_start = 1'b1;
    bus.next_line  = 10'd301;
    got_q.delete();
    acc_cnt = 0;
    req_cnt = 0;
    @(negedge clk);
    checks++;
    if (bus.rom_req !== 1'b0 || bus.lb_we !== 1'b0) begin
      errors++; $display("FAIL late_drop: req=%b we=%b expected 0 0", bus.rom_req, bus.lb_we);
    end
    @(posedge clk); #1;
    bus.line_start = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.late !== 1'b1) begin
      errors++; $display("FAIL late_pulse: got %b expected 1", bus.late);
    end
    @(posedge clk); #1;
    finish_job("late_restart", 1'b0);
  endtask

  task automatic test_reset_mid();
    clear_table();
    set_sprite(0, 1, 100, 200);
    gnt_random = 1'b0;
    start_line(10'd105);
    repeat (40) @(posedge clk);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    checks++;
    if (bus.rom_req !== 0 || bus.lb_we !== 0 || bus.busy !== 0 || bus.rom_addr !== 0
        || bus.attr_addr !== 0 || bus.done !== 0 || bus.late !== 0) begin
      errors++; $display("FAIL reset_mid: req=%b we=%b busy=%b raddr=%h aaddr=%h expected 0",
                         bus.rom_req, bus.lb_we, bus.busy, bus.rom_addr, bus.attr_addr);
    end
    @(negedge clk);
    reset = 1'b1;
    run_job(10'd110, 1'b0, "after_reset");
  endtask

  initial begin
    reset          = 1'b0;
    bus.line_start = 1'b0;
    bus.next_line  = '0;
    bus.attr_data  = '0;
    bus.rom_gnt    = 1'b0;
    bus.rom_data   = '0;
    clear_table();
    repeat (3) @(posedge clk);
    @(negedge clk);
    test_reset();
    reset = 1'b1;
    test_single();
    test_no_hit();
    test_overlap();
    test_overflow();
    test_right_edge();
    test_random();
    test_late();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
